// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges ex/clint/bus hold and redirect requests into one
// registered hold code plus a one-cycle pc redirect strobe.
//   clk, rst             : core clock, synchronous active-high reset
//   jump_req_i/addr_i    : ex redirect pulse and target
//   int_req_i/addr_i     : clint trap entry pulse and vector
//   hold_ex_i            : ex multi-cycle op busy (level)
//   hold_bus_i           : bus granted to an external master (level)
//   hold_flag_o          : 0 none, 1 pc, 2 if, 3 id
//   jump_flag_o/addr_o   : redirect strobe and target
//   busy_o               : controller not idle
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUS_HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_req_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        busy_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] BUS_MAX    = 8'(BUS_HOLD_MAX);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        EX_HOLD,
        BUS_HOLD,
        BUS_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  bus_cnt_q, bus_cnt_d;
    logic        jump_flag_d;
    logic [31:0] jump_addr_d;
    logic [2:0]  hold_d;
    logic        busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            bus_cnt_q   <= '0;
            hold_flag_o <= HOLD_NONE;
            jump_flag_o <= 1'b0;
            jump_addr_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            hold_flag_o <= hold_d;
            jump_flag_o <= jump_flag_d;
            jump_addr_o <= jump_addr_d;
            busy_o      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        bus_cnt_d   = bus_cnt_q;
        jump_flag_d = 1'b0;
        jump_addr_d = jump_addr_o;

        if (int_req_i || jump_req_i) begin
            // Redirect wins everywhere; int beats a same-cycle jump.
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
            bus_cnt_d   = '0;
            jump_flag_d = 1'b1;
            jump_addr_d = int_req_i ? int_addr_i : jump_addr_i;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hold_ex_i) begin
                        state_d = EX_HOLD;
                    end else if (hold_bus_i) begin
                        state_d   = BUS_HOLD;
                        bus_cnt_d = 8'd1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q != 3'd0) begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end else if (hold_ex_i) begin
                        state_d = EX_HOLD;
                    end else if (hold_bus_i) begin
                        state_d   = BUS_HOLD;
                        bus_cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EX_HOLD: begin
                    if (!hold_ex_i) begin
                        if (hold_bus_i) begin
                            state_d   = BUS_HOLD;
                            bus_cnt_d = 8'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                BUS_HOLD: begin
                    if (hold_ex_i) begin
                        state_d   = EX_HOLD;
                        bus_cnt_d = '0;
                    end else if (!hold_bus_i) begin
                        state_d   = IDLE;
                        bus_cnt_d = '0;
                    end else if (bus_cnt_q == BUS_MAX) begin
                        // Forced release so the core is not starved.
                        state_d   = BUS_GAP;
                        bus_cnt_d = '0;
                    end else begin
                        bus_cnt_d = bus_cnt_q + 8'd1;
                    end
                end
                BUS_GAP: begin
                    if (hold_ex_i) begin
                        state_d = EX_HOLD;
                    end else if (hold_bus_i) begin
                        state_d   = BUS_HOLD;
                        bus_cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    flush_cnt_d = '0;
                    bus_cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and then registered.
    always_comb begin
        hold_d = HOLD_NONE;
        unique case (state_d)
            FLUSH, EX_HOLD: hold_d = HOLD_ID;
            BUS_HOLD:       hold_d = HOLD_PC;
            default:        hold_d = HOLD_NONE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with queued expectations and a
// monitor that compares each cycle's registered outputs.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        hold_ex_i;
    logic        hold_bus_i;

    logic [2:0]  hold_a, hold_b;
    logic        jf_a, jf_b;
    logic [31:0] ja_a, ja_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(2), .BUS_HOLD_MAX(16)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .jump_req_i  (jump_req_i),
        .jump_addr_i (jump_addr_i),
        .int_req_i   (int_req_i),
        .int_addr_i  (int_addr_i),
        .hold_ex_i   (hold_ex_i),
        .hold_bus_i  (hold_bus_i),
        .hold_flag_o (hold_a),
        .jump_flag_o (jf_a),
        .jump_addr_o (ja_a),
        .busy_o      (busy_a)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .BUS_HOLD_MAX(16)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .jump_req_i  (jump_req_i),
        .jump_addr_i (jump_addr_i),
        .int_req_i   (int_req_i),
        .int_addr_i  (int_addr_i),
        .hold_ex_i   (hold_ex_i),
        .hold_bus_i  (hold_bus_i),
        .hold_flag_o (hold_b),
        .jump_flag_o (jf_b),
        .jump_addr_o (ja_b),
        .busy_o      (busy_b)
    );

    typedef struct packed {
        logic        sel;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] addr;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // One cycle: drive inputs after the falling edge and queue what the
    // selected DUT must show after the following rising edge.
    task automatic cyc(
        input logic r, ir, jr, ex, bus,
        input logic [31:0] ia, ja,
        input logic s,
        input logic [2:0] h,
        input logic jf,
        input logic [31:0] a,
        input logic b,
        input string nm
    );
        exp_t e;
        @(negedge clk);
        rst         = r;
        int_req_i   = ir;
        int_addr_i  = ia;
        jump_req_i  = jr;
        jump_addr_i = ja;
        hold_ex_i   = ex;
        hold_bus_i  = bus;
        e.sel  = s;
        e.hold = h;
        e.jf   = jf;
        e.addr = a;
        e.busy = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        exp_t        e;
        string       nm;
        logic [2:0]  h;
        logic        f;
        logic [31:0] a;
        logic        b;
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            h  = e.sel ? hold_b : hold_a;
            f  = e.sel ? jf_b : jf_a;
            a  = e.sel ? ja_b : ja_a;
            b  = e.sel ? busy_b : busy_a;
            n_cmp++;
            if (h !== e.hold || f !== e.jf || a !== e.addr || b !== e.busy) begin
                n_err++;
                $display("FAIL %s: got hold=%0d jf=%0b addr=%h busy=%0b, want hold=%0d jf=%0b addr=%h busy=%0b",
                         nm, h, f, a, b, e.hold, e.jf, e.addr, e.busy);
            end
        end
    end

    initial begin
        rst = 1'b1;
        int_req_i = 1'b0;
        int_addr_i = '0;
        jump_req_i = 1'b0;
        jump_addr_i = '0;
        hold_ex_i = 1'b0;
        hold_bus_i = 1'b0;

        // Reset, with a request in the reset cycle that must be dropped.
        cyc(1, 0, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0, "reset_discard");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");

        // Jump, FLUSH_CYCLES=2.
        cyc(0, 0, 1, 0, 0, 0, 32'h100, 0, 3, 1, 32'h100, 1, "jump_n1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h100, 1, "jump_n2");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, "jump_n3");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, "jump_addr_kept");

        // Same-cycle int and jump.
        cyc(0, 1, 1, 0, 0, 32'h4, 32'h200, 0, 3, 1, 32'h4, 1, "intjump_n1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h4, 1, "intjump_n2");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, "intjump_n3");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, "intjump_n4");

        // Reset mid-flush on the FLUSH_CYCLES=3 instance.
        cyc(0, 0, 1, 0, 0, 0, 32'h300, 1, 3, 1, 32'h300, 1, "rflush_n1");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h300, 1, "rflush_n2");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rflush_rst");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rflush_after");

        // hold_ex for 5 cycles with bus held throughout.
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 1, "ex_hold");
        for (int i = 1; i <= 16; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, "ex_to_bus");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "ex_bus_gap");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "ex_bus_release");

        // Bus held 40 cycles: 16 Pc, gap, 16 Pc, gap, 6 Pc.
        for (int i = 1; i <= 40; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0,
                (i == 17 || i == 34) ? 3'd0 : 3'd1, 0, 0, 1, "bus40");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "bus40_release");

        // Jump at bus_cnt=7; bus hold resumes counting from 1.
        for (int i = 1; i <= 7; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, "busj_pre");
        cyc(0, 0, 1, 0, 1, 0, 32'h700, 0, 3, 1, 32'h700, 1, "busj_strobe");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 32'h700, 1, "busj_flush");
        for (int i = 1; i <= 16; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h700, 1, "busj_resume");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h700, 1, "busj_gap");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h700, 0, "busj_release");

        // hold_ex preempts BUS_HOLD, then releases straight to idle.
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h700, 1, "preempt_bus");
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 32'h700, 1, "preempt_ex");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h700, 0, "preempt_rel");

        // hold_ex during BUS_GAP wins over returning to BUS_HOLD.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h700, 1, "gap_bus");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h700, 1, "gap_cycle");
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 32'h700, 1, "gap_ex");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h700, 0, "gap_rel");

        // A second redirect inside FLUSH restarts it.
        cyc(0, 0, 1, 0, 0, 0, 32'h800, 0, 3, 1, 32'h800, 1, "restart_n1");
        cyc(0, 0, 1, 0, 0, 0, 32'h900, 0, 3, 1, 32'h900, 1, "restart_n2");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h900, 1, "restart_n3");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h900, 0, "restart_n4");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. It merges hold and redirect requests from ex (jump, multi-cycle divide), clint (interrupt entry) and the bus arbiter (external master access) into one registered `hold_flag_o` code and one jump pulse. Those outputs drive the pc, if_id and id_ex pipeline registers. A small state machine enforces fixed flush lengths, request priority and a starvation bound on bus-granted stalls.

## Interface
- `FLUSH_CYCLES`, 1: number of cycles `hold_flag_o` stays at Hold_Id after a redirect; legal range 1–7.
- `BUS_HOLD_MAX`, 16: maximum consecutive cycles of bus-driven stall before a forced release cycle; legal range 2–255.
- `clk`  in  1  core clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `jump_req_i`  in  1  ex redirect request, single-cycle pulse.
- `jump_addr_i`  in  32  redirect target, valid with `jump_req_i`.
- `int_req_i`  in  1  clint interrupt entry, single-cycle pulse.
- `int_addr_i`  in  32  trap vector, valid with `int_req_i`.
- `hold_ex_i`  in  1  level; ex multi-cycle op busy.
- `hold_bus_i`  in  1  level; bus arbiter granting an external master.
- `hold_flag_o`  out  3  Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
- `jump_flag_o`  out  1  one-cycle pc redirect strobe.
- `jump_addr_o`  out  32  redirect target, valid while `jump_flag_o`=1.
- `busy_o`  out  1  controller not in IDLE.

## Operation
- States: IDLE, FLUSH, EX_HOLD, BUS_HOLD, BUS_GAP. All outputs are registered from the state and counters.
- Outputs per state:
  - IDLE: `hold_flag_o`=Hold_None.
  - FLUSH: Hold_Id.
  - EX_HOLD: Hold_Id.
  - BUS_HOLD: Hold_Pc.
  - BUS_GAP: Hold_None.
- Priority at each sampling edge, highest first:
  1. `int_req_i`
  2. `jump_req_i`
  3. `hold_ex_i`
  4. `hold_bus_i`
- Redirect (int or jump), accepted from any state:
  - Load `jump_addr_o` with `int_addr_i` or `jump_addr_i`.
  - Assert `jump_flag_o` for exactly one cycle.
  - Enter FLUSH with `flush_cnt`=FLUSH_CYCLES−1.
- Simultaneous int and jump in the same cycle: the int wins and the jump is dropped. Ex's jump is squashed by the flush.
- FLUSH:
  - Decrement `flush_cnt` each cycle.
  - At 0, go to IDLE, or go directly to EX_HOLD or BUS_HOLD if the corresponding level request is high.
  - A new redirect inside FLUSH restarts the flush with the new target.
- EX_HOLD: remain while `hold_ex_i`=1. On deassert, go to BUS_HOLD if `hold_bus_i`=1, else IDLE.
- BUS_HOLD:
  - `bus_cnt` increments from 1.
  - When `bus_cnt`=BUS_HOLD_MAX with `hold_bus_i` still high, go to BUS_GAP for exactly one cycle, then return to BUS_HOLD with `bus_cnt`=1.
  - `hold_ex_i` rising during BUS_HOLD preempts to EX_HOLD; `bus_cnt` is cleared.
- BUS_GAP: `hold_ex_i` or a redirect takes precedence over returning to BUS_HOLD.
- `busy_o`=1 in every state except IDLE.
- Reset values (any cycle, including mid-flush or mid-stall):
  - state=IDLE
  - `hold_flag_o`=Hold_None
  - `jump_flag_o`=0
  - `jump_addr_o`=0
  - `busy_o`=0
  - all counters=0
- A request present in the reset cycle is discarded.

## Timing
- One-cycle latency: a request sampled at edge N appears on the outputs after edge N (cycle N+1).
- Redirect: `jump_flag_o` is high in cycle N+1 only. `hold_flag_o`=Hold_Id in cycles N+1 … N+FLUSH_CYCLES.
- Level-request release: `hold_flag_o` drops one cycle after `hold_ex_i`/`hold_bus_i` deasserts.
- Bus starvation bound: with `hold_bus_i` held continuously, `hold_flag_o` shows at most BUS_HOLD_MAX consecutive Hold_Pc cycles, then one Hold_None cycle.
- `jump_addr_o` holds its last value after the strobe; it changes only on an accepted redirect or on reset.

## Test plan
- Reset: assert `rst` mid-FLUSH with FLUSH_CYCLES=3 → next cycle `hold_flag_o`=0, `jump_flag_o`=0, `jump_addr_o`=0, `busy_o`=0.
- Jump pulse with `jump_addr_i`=0x0000_0100 at edge N (FLUSH_CYCLES=2) → `jump_flag_o`=1 only in N+1, `jump_addr_o`=0x100, `hold_flag_o`=3 in N+1..N+2, 0 in N+3.
- Same-cycle `int_req_i` (`int_addr_i`=0x0000_0004) and `jump_req_i` (`jump_addr_i`=0x200) → `jump_addr_o`=0x4, exactly one `jump_flag_o` pulse.
- `hold_ex_i` high 5 cycles with `hold_bus_i` high throughout → Hold_Id for 5 cycles, then Hold_Pc, counter starting at 1.
- `hold_bus_i` high for 40 cycles, BUS_HOLD_MAX=16 → 16×Hold_Pc, 1×Hold_None, 16×Hold_Pc, 1×Hold_None, 6×Hold_Pc, then Hold_None.
- Jump during BUS_HOLD at `bus_cnt`=7 → redirect strobe, Hold_Id flush, then BUS_HOLD resumes with `bus_cnt`=1.
